// File: rtl/ws2812_frame_streamer_pkg.sv
// Shared constants for the WS2812 frame streamer: FSM encoding, frame-buffer
// read latency and default WS2812 timing at a 40 MHz clock.
package ws2812_frame_streamer_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   // Edges between presenting cs1_n=0 and rdata1 becoming valid.
   localparam int RD_LATENCY = 2;

   localparam int DEF_TBIT   = 50;
   localparam int DEF_T0H    = 16;
   localparam int DEF_T1H    = 32;
   localparam int DEF_TRESET = 2000;

   // Timing parameters are usable only when both high times fit inside a bit.
   function automatic logic ws_params_ok(input int tbit, input int t0h,
                                         input int t1h, input int treset);
      return (t0h > 0) && (t0h < t1h) && (t1h < tbit) &&
             (tbit >= 4) && (treset >= 1);
   endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Produces one WS2812 bit period: high for T0H/T1H clocks, low for the rest
// of TBIT. A start strobe in the last cycle of a bit chains the next bit with
// no gap; bit_done flags that last cycle.
module ws2812_bit_encoder
   import ws2812_frame_streamer_pkg::*;
#(
   parameter int TBIT = DEF_TBIT,
   parameter int T0H  = DEF_T0H,
   parameter int T1H  = DEF_T1H
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_start,
   input  logic bit_val,
   output logic led_out,
   output logic bit_done
);

   localparam int CW = $clog2(TBIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] HI0      = CW'(T0H);
   localparam logic [CW-1:0] HI1      = CW'(T1H);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          bit_r;
   logic          active_r;
   logic          led_r;

   // Next counter value and end-of-bit strobe.
   always_comb begin
      cnt_nxt_s = cnt_r + CNT_ONE;
      bit_done  = active_r && (cnt_r == CNT_LAST);
   end

   // Bit-period counter and registered line level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r    <= CNT_ZERO;
         bit_r    <= 1'b0;
         active_r <= 1'b0;
         led_r    <= 1'b0;
      end else if (bit_start) begin
         cnt_r    <= CNT_ZERO;
         bit_r    <= bit_val;
         active_r <= 1'b1;
         led_r    <= 1'b1;
      end else if (bit_done) begin
         cnt_r    <= CNT_ZERO;
         active_r <= 1'b0;
         led_r    <= 1'b0;
      end else if (active_r) begin
         cnt_r    <= cnt_nxt_s;
         led_r    <= (cnt_nxt_s < (bit_r ? HI1 : HI0));
      end else begin
         led_r    <= 1'b0;
      end
   end

   assign led_out = led_r;

endmodule

// File: rtl/ws2812_frame_streamer.sv
// Streams a run of pixel words from the frame buffer's read port onto a
// WS2812 data line, MSB first, prefetching each next pixel while the current
// one shifts, then holds the line low for the latch gap and pulses done.
module ws2812_frame_streamer
   import ws2812_frame_streamer_pkg::*;
#(
   parameter int ASIZE  = 8,
   parameter int DSIZE  = 24,
   parameter int TBIT   = DEF_TBIT,
   parameter int T0H    = DEF_T0H,
   parameter int T1H    = DEF_T1H,
   parameter int TRESET = DEF_TRESET
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ASIZE-1:0] base_addr,
   input  logic [ASIZE:0]   pixel_count,
   output logic             busy,
   output logic             done,
   output logic             cs1_n,
   output logic [ASIZE-1:0] addr1,
   input  logic [DSIZE-1:0] rdata1,
   output logic             led_out
);

   localparam int RW = ASIZE + 1;
   localparam int BW = $clog2(DSIZE);
   localparam int GW = $clog2(TRESET + 1);
   localparam logic [RW-1:0] REM_ZERO  = RW'(0);
   localparam logic [RW-1:0] REM_ONE   = RW'(1);
   localparam logic [BW-1:0] BIDX_MSB  = BW'(DSIZE - 1);
   localparam logic [BW-1:0] BIDX_ZERO = BW'(0);
   localparam logic [BW-1:0] BIDX_ONE  = BW'(1);
   localparam logic [GW-1:0] GAP_ZERO  = GW'(0);
   localparam logic [GW-1:0] GAP_ONE   = GW'(1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TRESET - 1);

   if (!ws_params_ok(TBIT, T0H, T1H, TRESET)) begin : g_bad_timing
      $error("ws2812_frame_streamer: need 0<T0H<T1H<TBIT, TBIT>=4, TRESET>=1");
   end

   state_t              state_r;
   logic [ASIZE-1:0]    addr_r;
   logic [RW-1:0]       rem_r;
   logic [DSIZE-1:0]    shift_r;
   logic [DSIZE-1:0]    pf_r;
   logic [BW-1:0]       bit_idx_r;
   logic [RD_LATENCY:0] rd_pipe_r;
   logic [GW-1:0]       gap_cnt_r;
   logic                busy_r;
   logic                done_r;
   logic                cs1_n_r;

   logic accept_s, zero_start_s, load_first_s, last_bit_s;
   logic more_bits_s, next_pix_s, end_frame_s, prefetch_s, issue_s;
   logic enc_start_s, enc_bit_s, bit_done_s;

   ws2812_bit_encoder #(
      .TBIT (TBIT),
      .T0H  (T0H),
      .T1H  (T1H)
   ) u_enc (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_start (enc_start_s),
      .bit_val   (enc_bit_s),
      .led_out   (led_out),
      .bit_done  (bit_done_s)
   );

   // Decode start acceptance, bit/pixel boundaries and read issue.
   always_comb begin
      accept_s     = 1'b0;
      zero_start_s = 1'b0;
      if ((state_r == ST_IDLE) && start && !done_r) begin
         if (pixel_count != REM_ZERO) begin
            accept_s = 1'b1;
         end else begin
            zero_start_s = 1'b1;
         end
      end else begin
         accept_s     = 1'b0;
         zero_start_s = 1'b0;
      end
      load_first_s = (state_r == ST_WAIT) && rd_pipe_r[RD_LATENCY];
      last_bit_s   = (state_r == ST_SHIFT) && bit_done_s;
      more_bits_s  = last_bit_s && (bit_idx_r != BIDX_ZERO);
      next_pix_s   = last_bit_s && (bit_idx_r == BIDX_ZERO) && (rem_r != REM_ZERO);
      end_frame_s  = last_bit_s && (bit_idx_r == BIDX_ZERO) && (rem_r == REM_ZERO);
      // rem_r still counts the pixel being loaded, so >1 means one more follows.
      prefetch_s   = (load_first_s || next_pix_s) && (rem_r > REM_ONE);
      issue_s      = accept_s || prefetch_s;
      enc_start_s  = load_first_s || more_bits_s || next_pix_s;
      if (load_first_s) begin
         enc_bit_s = rdata1[DSIZE-1];
      end else if (next_pix_s) begin
         enc_bit_s = pf_r[DSIZE-1];
      end else begin
         enc_bit_s = shift_r[DSIZE-2];
      end
   end

   // Frame FSM, address/pixel counters, shift and prefetch registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         addr_r    <= {ASIZE{1'b0}};
         rem_r     <= REM_ZERO;
         shift_r   <= {DSIZE{1'b0}};
         pf_r      <= {DSIZE{1'b0}};
         bit_idx_r <= BIDX_ZERO;
         rd_pipe_r <= {(RD_LATENCY+1){1'b0}};
         gap_cnt_r <= GAP_ZERO;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cs1_n_r   <= 1'b1;
      end else begin
         done_r    <= 1'b0;
         cs1_n_r   <= ~issue_s;
         rd_pipe_r <= {rd_pipe_r[RD_LATENCY-1:0], issue_s};
         if (prefetch_s) begin
            addr_r <= addr_r + ASIZE'(1);
         end
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  addr_r  <= base_addr;
                  rem_r   <= pixel_count;
                  busy_r  <= 1'b1;
                  state_r <= ST_FETCH;
               end else if (zero_start_s) begin
                  done_r  <= 1'b1;
               end
            end
            ST_FETCH: begin
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (load_first_s) begin
                  shift_r   <= rdata1;
                  rem_r     <= rem_r - REM_ONE;
                  bit_idx_r <= BIDX_MSB;
                  state_r   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (rd_pipe_r[RD_LATENCY]) begin
                  pf_r <= rdata1;
               end
               if (more_bits_s) begin
                  shift_r   <= {shift_r[DSIZE-2:0], 1'b0};
                  bit_idx_r <= bit_idx_r - BIDX_ONE;
               end else if (next_pix_s) begin
                  shift_r   <= pf_r;
                  rem_r     <= rem_r - REM_ONE;
                  bit_idx_r <= BIDX_MSB;
               end else if (end_frame_s) begin
                  gap_cnt_r <= GAP_ZERO;
                  state_r   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_ONE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign cs1_n = cs1_n_r;
   assign addr1 = addr_r;

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// Self-checking bench for ws2812_frame_streamer with a 2-cycle frame-buffer
// model. Expected line waveforms come from the WS2812 bit rules applied to
// the memory contents directly.
module tb_ws2812_frame_streamer;

   localparam int TB_TBIT   = 10;
   localparam int TB_T0H    = 3;
   localparam int TB_T1H    = 7;
   localparam int TB_TRESET = 20;
   localparam int TB_DSIZE  = 24;
   localparam int PIX_CLKS  = TB_DSIZE * TB_TBIT;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  pixel_count;
   logic        busy;
   logic        done;
   logic        cs1_n;
   logic [7:0]  addr1;
   logic [23:0] rdata1;
   logic        led_out;

   logic [23:0] mem [256];
   logic [7:0]  bq;
   logic        bv;
   logic [7:0]  rd_q [$];

   int checks = 0;
   int errors = 0;

   ws2812_frame_streamer #(
      .ASIZE  (8),
      .DSIZE  (TB_DSIZE),
      .TBIT   (TB_TBIT),
      .T0H    (TB_T0H),
      .T1H    (TB_T1H),
      .TRESET (TB_TRESET)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .pixel_count (pixel_count),
      .busy        (busy),
      .done        (done),
      .cs1_n       (cs1_n),
      .addr1       (addr1),
      .rdata1      (rdata1),
      .led_out     (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame buffer: registered inputs, data out two edges later.
   always @(posedge clk) begin
      bv <= (cs1_n == 1'b0);
      bq <= addr1;
      if (bv) rdata1 <= mem[bq];
   end

   // Record every read address presented to the buffer.
   always @(negedge clk) begin
      if (cs1_n === 1'b0) rd_q.push_back(addr1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected line level k cycles after the start edge.
   function automatic logic led_at(input logic [7:0] base, input int n, input int k);
      int t, p, r, b, j;
      logic [23:0] w;
      logic [7:0]  a;
      if (k < 3) return 1'b0;
      t = k - 3;
      if (t >= n * PIX_CLKS) return 1'b0;
      p = t / PIX_CLKS;
      r = t % PIX_CLKS;
      b = r / TB_TBIT;
      j = r % TB_TBIT;
      a = base + 8'(p);
      w = mem[a];
      return (j < (w[TB_DSIZE-1-b] ? TB_T1H : TB_T0H));
   endfunction

   // Launch a frame (caller is at a negedge) and check it through its done cycle.
   task automatic run_frame(input logic [7:0] base, input int n, input int poke_k, input string tag);
      int d, mism, done_k, done_n, busy_n;
      logic [7:0] a;
      rd_q.delete();
      base_addr   = base;
      pixel_count = 9'(n);
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      base_addr   = 8'($urandom);
      pixel_count = 9'($urandom_range(1, 3));
      d = 3 + n * PIX_CLKS + TB_TRESET;
      mism = 0; done_k = -1; done_n = 0; busy_n = 0;
      for (int k = 0; k <= d; k++) begin
         if (led_out !== led_at(base, n, k)) mism++;
         if (done === 1'b1) begin
            done_n++;
            if (done_k < 0) done_k = k;
         end
         if (busy === 1'b1) busy_n++;
         start = (k == poke_k);
         if (k < d) @(negedge clk);
      end
      chk({tag, "_led_wave_errs"}, mism, 0);
      chk({tag, "_done_cycle"}, done_k, d);
      chk({tag, "_done_pulses"}, done_n, 1);
      chk({tag, "_busy_cycles"}, busy_n, d);
      chk({tag, "_read_count"}, rd_q.size(), n);
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
         a = base + 8'(i);
         chk({tag, "_read_addr"}, int'(rd_q[i]), int'(a));
      end
   endtask

   initial begin
      int zl, zb, zd;
      rst_n       = 1'b0;
      start       = 1'b0;
      base_addr   = 8'h00;
      pixel_count = 9'd0;
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_led", int'(led_out), 0);
      chk("rst_cs1_n", int'(cs1_n), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr1", int'(addr1), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single pixel.
      mem[8'h10] = 24'hA50F3C;
      run_frame(8'h10, 1, -1, "t1");
      repeat (2) @(negedge clk);
      chk("t1_busy_after", int'(busy), 0);

      // Three back-to-back pixels.
      mem[8'h00] = 24'hFFFFFF;
      mem[8'h01] = 24'h000000;
      mem[8'h02] = 24'h800001;
      run_frame(8'h00, 3, -1, "t2");
      repeat (2) @(negedge clk);

      // Address wrap.
      run_frame(8'hFF, 2, -1, "t3");
      repeat (2) @(negedge clk);

      // Zero-length frame.
      rd_q.delete();
      base_addr   = 8'h33;
      pixel_count = 9'd0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4_done_next", int'(done), 1);
      chk("t4_busy", int'(busy), 0);
      zl = 0; zb = 0; zd = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (led_out !== 1'b0) zl++;
         if (busy !== 1'b0) zb++;
         if (done !== 1'b0) zd++;
      end
      chk("t4_led_high", zl, 0);
      chk("t4_busy_high", zb, 0);
      chk("t4_extra_done", zd, 0);
      chk("t4_reads", rd_q.size(), 0);

      // Start mid-frame and in the done cycle are ignored; one cycle later is not.
      run_frame(8'h20, 2, 100, "t5a");
      start       = 1'b1;
      base_addr   = 8'h77;
      pixel_count = 9'd2;
      @(negedge clk);
      start = 1'b0;
      chk("t5_done_cycle_start_busy", int'(busy), 0);
      chk("t5_done_cycle_start_cs", int'(cs1_n), 1);
      run_frame(8'h30, 1, -1, "t5b");
      repeat (2) @(negedge clk);

      // Reset during the 5th bit of pixel 2, then replay.
      base_addr   = 8'h40;
      pixel_count = 9'd3;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3 + PIX_CLKS + 4 * TB_TBIT + 2; k++) @(negedge clk);
      chk("t6_led_before_reset", int'(led_out), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_led", int'(led_out), 0);
      chk("t6_rst_cs1_n", int'(cs1_n), 1);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_frame(8'h40, 3, -1, "t6_replay");
      repeat (2) @(negedge clk);

      // Randomized frames.
      for (int f = 0; f < 3; f++) begin
         run_frame(8'($urandom), int'($urandom_range(1, 3)), -1, "rnd");
         repeat (2) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
